mouse_cursor_tracker: RTL and testbench
=======================================

// Module: mouse_cursor_tracker
// PURPOSE
//  Consumes decoded PS/2 mouse packets (button states plus 9-bit two's-complement
//  X/Y increments with a one-cycle DataReady strobe) from the mouse interface.
//  Accumulates them into clamped screen-cursor coordinates and emits button edge
//  and double-click pulses. Sits between the PS/2 mouse decoder and display/UI logic.
// PARAMETERS
//  CW            10         cursor coordinate width (bits, unsigned)
//  XMAX          639        largest legal CursorX value
//  YMAX          479        largest legal CursorY value
//  X_INIT        320        CursorX after reset/Recenter
//  Y_INIT        240        CursorY after reset/Recenter
//  SHIFT         0          speed scaling: delta << SHIFT (0..3)
//  YINVERT       1          1: PS/2 +Y (up) decreases CursorY (screen down-positive)
//  DBLCLK_CYCLES 12500000   double-click window in Clk cycles (250 ms at 50 MHz)
// PORTS
//  Clk          in   1   system clock, all logic on rising edge
//  Reset        in   1   asynchronous, active-low reset
//  DataReady    in   1   one-cycle strobe: packet fields below are valid this cycle
//  LeftButton   in   1   left button state from packet (1 = pressed)
//  RightButton  in   1   right button state from packet
//  XIncrement   in   9   X delta, two's complement, -256..+255
//  YIncrement   in   9   Y delta, two's complement, +Y = mouse moved up
//  Recenter     in   1   synchronous request: force cursor to X_INIT/Y_INIT
//  CursorX      out  CW  current cursor X, 0..XMAX
//  CursorY      out  CW  current cursor Y, 0..YMAX
//  Valid        out  1   one-cycle pulse: cursor/edges just updated from a packet
//  EdgeHit      out  4   {bottom,top,right,left} clamp occurred; pulses with Valid
//  LeftDown/LeftUp/RightDown/RightUp  out 1 each  button edge pulses, with Valid
//  DoubleClick  out  1   one-cycle pulse, second LeftDown within window, with Valid
// BEHAVIOUR
//  Reset (Reset=0, async): CursorX=X_INIT, CursorY=Y_INIT; Valid, EdgeHit, all
//   edge pulses, DoubleClick = 0; stored button states 0; pipeline empty;
//   double-click FSM IDLE, counter 0. Packets in flight at reset are discarded.
//  Stage 1 (cycle n, DataReady=1): register sign-extended deltas, left-shifted by SHIFT.
//   Y is negated when YINVERT=1. Also register buttons and their edges vs previous state.
//   Previous button state updates only on accepted packets.
//  Stage 2 (cycle n+1): compute sum = Cursor + delta, signed, width CW+SHIFT+2.
//   sum<0 -> 0 with EdgeHit left/top; sum>MAX -> MAX with EdgeHit right/bottom.
//   Cursor registers load the clamped result.
//  Outputs visible cycle n+2: Valid and pulses high exactly one cycle.
//   Fixed latency 2; a packet is accepted every cycle (back-to-back DataReady allowed).
//   Consecutive packets accumulate in order: stage 2 uses the just-updated cursor.
//  Double-click FSM: IDLE --LeftDown--> ARMED (counter := 0, increments per cycle).
//   ARMED --LeftDown with counter < DBLCLK_CYCLES--> DoubleClick pulse, -> IDLE.
//   ARMED --counter reaches DBLCLK_CYCLES--> IDLE.
//   A third click after a DoubleClick re-arms (acts as a first click).
//  Recenter=1: cursor := X_INIT/Y_INIT next cycle. Both stages are flushed, so no
//   Valid and no pulses are generated for in-flight packets. A DataReady in the same
//   cycle is dropped entirely (button history not updated). FSM -> IDLE.
//  Zero delta with no button change still produces Valid with unchanged cursor.
// TESTING
//  1 reset release -> CursorX=320, CursorY=240, Valid/EdgeHit/pulses 0.
//  2 DataReady X=9'h005, Y=9'h003 (YINVERT=1) -> 2 cycles later CursorX=325,
//    CursorY=237, Valid high one cycle, EdgeHit=0.
//  3 two packets X=9'h100 (-256) from 320 -> 64 then 0; EdgeHit[0]=1 on second only.
//  4 4 back-to-back DataReady X=+100 -> CursorX 420,520,620,639 on consecutive
//    cycles; EdgeHit[1]=1 on last.
//  5 DBLCLK_CYCLES=100: L press, release, press within 50 cycles -> LeftDown, LeftUp,
//    LeftDown+DoubleClick; repeat with 150-cycle gap -> no DoubleClick.
//  6 Recenter with DataReady same cycle -> cursor 320/240, no Valid; Reset low
//    one cycle after DataReady -> no Valid after release, cursor at init.

Source files
------------

// File: rtl/mouse_cursor_tracker.sv
// Accumulates decoded PS/2 mouse packets into clamped screen-cursor coordinates
// and produces button edge and double-click pulses with a fixed two-cycle latency.
module mouse_cursor_tracker #(
  parameter int unsigned CW            = 10,
  parameter int unsigned XMAX          = 639,
  parameter int unsigned YMAX          = 479,
  parameter int unsigned X_INIT        = 320,
  parameter int unsigned Y_INIT        = 240,
  parameter int unsigned SHIFT         = 0,
  parameter int unsigned YINVERT       = 1,
  parameter int unsigned DBLCLK_CYCLES = 12500000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_ready_i,
  input  logic          left_button_i,
  input  logic          right_button_i,
  input  logic [8:0]    x_increment_i,
  input  logic [8:0]    y_increment_i,
  input  logic          recenter_i,
  output logic [CW-1:0] cursor_x_o,
  output logic [CW-1:0] cursor_y_o,
  output logic          valid_o,
  output logic [3:0]    edge_hit_o,
  output logic          left_down_o,
  output logic          left_up_o,
  output logic          right_down_o,
  output logic          right_up_o,
  output logic          double_click_o
);

  localparam int unsigned SW   = CW + SHIFT + 2;
  localparam int unsigned CNTW = $clog2(DBLCLK_CYCLES + 1);

  typedef enum logic {DC_IDLE, DC_ARMED} dc_state_e;

  logic                 accept_c;
  logic signed [SW-1:0] x_ext_c, y_ext_c, y_adj_c, sum_x_c, sum_y_c;

  logic                 s1_vld_q, s1_vld_d;
  logic signed [SW-1:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic                 s1_ld_q, s1_ld_d, s1_lu_q, s1_lu_d;
  logic                 s1_rd_q, s1_rd_d, s1_ru_q, s1_ru_d;
  logic                 prev_left_q, prev_left_d, prev_right_q, prev_right_d;

  logic [CW-1:0]        cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic                 valid_q, valid_d;
  logic [3:0]           edge_hit_q, edge_hit_d;
  logic                 ld_q, ld_d, lu_q, lu_d, rd_q, rd_d, ru_q, ru_d;

  dc_state_e            dc_state_q;
  logic [CNTW-1:0]      dc_cnt_q;
  logic                 dbl_q;

  // Stage 1 capture and stage 2 accumulate/clamp
  always_comb begin
    accept_c     = data_ready_i && !recenter_i;
    x_ext_c      = SW'($signed(x_increment_i)) <<< SHIFT;
    y_ext_c      = SW'($signed(y_increment_i)) <<< SHIFT;
    y_adj_c      = (YINVERT != 0) ? -y_ext_c : y_ext_c;

    s1_vld_d     = accept_c;
    s1_dx_d      = x_ext_c;
    s1_dy_d      = y_adj_c;
    s1_ld_d      = left_button_i  && !prev_left_q;
    s1_lu_d      = !left_button_i && prev_left_q;
    s1_rd_d      = right_button_i && !prev_right_q;
    s1_ru_d      = !right_button_i && prev_right_q;
    prev_left_d  = accept_c ? left_button_i  : prev_left_q;
    prev_right_d = accept_c ? right_button_i : prev_right_q;

    sum_x_c      = $signed(SW'(cursor_x_q)) + s1_dx_q;
    sum_y_c      = $signed(SW'(cursor_y_q)) + s1_dy_q;

    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    valid_d      = 1'b0;
    edge_hit_d   = 4'b0000;
    ld_d         = 1'b0;
    lu_d         = 1'b0;
    rd_d         = 1'b0;
    ru_d         = 1'b0;

    if (recenter_i) begin
      cursor_x_d = CW'(X_INIT);
      cursor_y_d = CW'(Y_INIT);
    end else if (s1_vld_q) begin
      valid_d = 1'b1;
      ld_d    = s1_ld_q;
      lu_d    = s1_lu_q;
      rd_d    = s1_rd_q;
      ru_d    = s1_ru_q;
      if (sum_x_c[SW-1]) begin
        cursor_x_d    = '0;
        edge_hit_d[0] = 1'b1;
      end else if (sum_x_c > $signed(SW'(XMAX))) begin
        cursor_x_d    = CW'(XMAX);
        edge_hit_d[1] = 1'b1;
      end else begin
        cursor_x_d    = sum_x_c[CW-1:0];
      end
      if (sum_y_c[SW-1]) begin
        cursor_y_d    = '0;
        edge_hit_d[2] = 1'b1;
      end else if (sum_y_c > $signed(SW'(YMAX))) begin
        cursor_y_d    = CW'(YMAX);
        edge_hit_d[3] = 1'b1;
      end else begin
        cursor_y_d    = sum_y_c[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q     <= 1'b0;
      s1_dx_q      <= '0;
      s1_dy_q      <= '0;
      s1_ld_q      <= 1'b0;
      s1_lu_q      <= 1'b0;
      s1_rd_q      <= 1'b0;
      s1_ru_q      <= 1'b0;
      prev_left_q  <= 1'b0;
      prev_right_q <= 1'b0;
      cursor_x_q   <= CW'(X_INIT);
      cursor_y_q   <= CW'(Y_INIT);
      valid_q      <= 1'b0;
      edge_hit_q   <= 4'b0000;
      ld_q         <= 1'b0;
      lu_q         <= 1'b0;
      rd_q         <= 1'b0;
      ru_q         <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_dx_q      <= s1_dx_d;
      s1_dy_q      <= s1_dy_d;
      s1_ld_q      <= s1_ld_d;
      s1_lu_q      <= s1_lu_d;
      s1_rd_q      <= s1_rd_d;
      s1_ru_q      <= s1_ru_d;
      prev_left_q  <= prev_left_d;
      prev_right_q <= prev_right_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      valid_q      <= valid_d;
      edge_hit_q   <= edge_hit_d;
      ld_q         <= ld_d;
      lu_q         <= lu_d;
      rd_q         <= rd_d;
      ru_q         <= ru_d;
    end
  end

  // Double-click detector; a LeftDown arriving outside the window re-arms it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dc_state_q <= DC_IDLE;
      dc_cnt_q   <= '0;
      dbl_q      <= 1'b0;
    end else begin
      dbl_q <= 1'b0;
      if (recenter_i) begin
        dc_state_q <= DC_IDLE;
        dc_cnt_q   <= '0;
      end else begin
        case (dc_state_q)
          DC_IDLE: begin
            if (s1_vld_q && s1_ld_q) begin
              dc_state_q <= DC_ARMED;
              dc_cnt_q   <= '0;
            end
          end
          DC_ARMED: begin
            if (s1_vld_q && s1_ld_q && (dc_cnt_q < CNTW'(DBLCLK_CYCLES))) begin
              dbl_q      <= 1'b1;
              dc_state_q <= DC_IDLE;
              dc_cnt_q   <= '0;
            end else if (s1_vld_q && s1_ld_q) begin
              dc_cnt_q   <= '0;
            end else if (dc_cnt_q >= CNTW'(DBLCLK_CYCLES)) begin
              dc_state_q <= DC_IDLE;
              dc_cnt_q   <= '0;
            end else begin
              dc_cnt_q   <= dc_cnt_q + CNTW'(1);
            end
          end
          default: begin
            dc_state_q <= DC_IDLE;
            dc_cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign cursor_x_o     = cursor_x_q;
  assign cursor_y_o     = cursor_y_q;
  assign valid_o        = valid_q;
  assign edge_hit_o     = edge_hit_q;
  assign left_down_o    = ld_q;
  assign left_up_o      = lu_q;
  assign right_down_o   = rd_q;
  assign right_up_o     = ru_q;
  assign double_click_o = dbl_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Scoreboard bench: a packet-level cursor/button model queues expected results,
// a negedge monitor pops and compares them whenever the tracker asserts valid.
module tb_mouse_cursor_tracker;

  localparam int DBL = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_ready = 1'b0, left_b = 1'b0, right_b = 1'b0, recenter = 1'b0;
  logic [8:0] x_inc = '0, y_inc = '0;
  logic [9:0] cursor_x, cursor_y;
  logic       valid, ld, lu, rd, ru, dbl;
  logic [3:0] edge_hit;

  mouse_cursor_tracker #(.DBLCLK_CYCLES(DBL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_ready_i(data_ready),
    .left_button_i(left_b), .right_button_i(right_b),
    .x_increment_i(x_inc), .y_increment_i(y_inc), .recenter_i(recenter),
    .cursor_x_o(cursor_x), .cursor_y_o(cursor_y), .valid_o(valid),
    .edge_hit_o(edge_hit), .left_down_o(ld), .left_up_o(lu),
    .right_down_o(rd), .right_up_o(ru), .double_click_o(dbl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x, y;
    logic [3:0] e;
    logic       ld, lu, rd, ru, dbl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0, dbl_seen = 0;

  // Reference model state: cursor, button history, one packet in flight
  int   m_x, m_y, m_cyc, m_tarm;
  logic m_pl, m_pr, m_armed;
  logic p_v;
  int   p_dx, p_dy;
  logic p_ld, p_lu, p_rd, p_ru;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_x = 320; m_y = 240; m_pl = 1'b0; m_pr = 1'b0;
    m_armed = 1'b0; m_tarm = 0; p_v = 1'b0;
  endfunction

  function automatic void model_apply();
    exp_t r;
    int nx, ny;
    nx = m_x + p_dx;
    ny = m_y + p_dy;
    r.e = 4'b0000;
    if (nx < 0) begin nx = 0; r.e[0] = 1'b1; end
    else if (nx > 639) begin nx = 639; r.e[1] = 1'b1; end
    if (ny < 0) begin ny = 0; r.e[2] = 1'b1; end
    else if (ny > 479) begin ny = 479; r.e[3] = 1'b1; end
    m_x = nx; m_y = ny;
    r.x = nx; r.y = ny;
    r.ld = p_ld; r.lu = p_lu; r.rd = p_rd; r.ru = p_ru;
    r.dbl = 1'b0;
    if (p_ld) begin
      if (m_armed && (m_cyc - m_tarm) <= DBL) begin
        r.dbl = 1'b1;
        m_armed = 1'b0;
      end else begin
        m_armed = 1'b1;
        m_tarm = m_cyc;
      end
    end
    sb.push_back(r);
  endfunction

  function automatic void model_step(input logic dr, input logic l, input logic r,
                                     input logic [8:0] x, input logic [8:0] y, input logic rc);
    if (rc) begin
      p_v = 1'b0; m_x = 320; m_y = 240; m_armed = 1'b0;
    end else begin
      if (p_v) model_apply();
      p_v = dr;
      if (dr) begin
        p_dx = int'($signed(x));
        p_dy = -int'($signed(y));
        p_ld = l && !m_pl; p_lu = !l && m_pl;
        p_rd = r && !m_pr; p_ru = !r && m_pr;
        m_pl = l; m_pr = r;
      end
    end
    m_cyc++;
  endfunction

  task automatic step(input logic dr, input logic l, input logic r,
                      input logic [8:0] x, input logic [8:0] y, input logic rc);
    data_ready = dr; left_b = l; right_b = r; x_inc = x; y_inc = y; recenter = rc;
    model_step(dr, l, r, x, y, rc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(valid), 64'(1'b0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("packet_result",
              64'({cursor_x, cursor_y, edge_hit, ld, lu, rd, ru, dbl}),
              64'({10'(e.x), 10'(e.y), e.e, e.ld, e.lu, e.rd, e.ru, e.dbl}));
        end
        if (dbl) dbl_seen++;
      end else begin
        chk("idle_pulses", 64'({edge_hit, ld, lu, rd, ru, dbl}), 64'(0));
      end
    end
  end

  initial begin
    model_reset();
    m_cyc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_state", 64'({cursor_x, cursor_y, valid, edge_hit, ld, lu, rd, ru, dbl}),
        64'({10'd320, 10'd240, 10'b0}));

    step(1'b1, 1'b0, 1'b0, 9'h005, 9'h003, 1'b0);
    idle(3);
    chk("small_move", 64'({cursor_x, cursor_y}), 64'({10'd325, 10'd237}));

    step(1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 9'h100, 9'h000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 9'h100, 9'h000, 1'b0);
    idle(3);
    chk("left_clamp", 64'({cursor_x, cursor_y}), 64'({10'd0, 10'd240}));

    step(1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 9'd100, 9'h000, 1'b0);
    idle(3);
    chk("right_clamp", 64'(cursor_x), 64'(10'd639));

    step(1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1);
    step(1'b1, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(10);
    step(1'b1, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(5);
    chk("dblclk_within", 64'(dbl_seen), 64'(1));
    step(1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(10);
    step(1'b1, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(150);
    step(1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(5);
    chk("dblclk_expired", 64'(dbl_seen), 64'(1));

    step(1'b1, 1'b0, 1'b0, 9'd7, 9'd7, 1'b0);
    step(1'b1, 1'b0, 1'b1, 9'd50, 9'd50, 1'b1);
    idle(4);
    chk("recenter_drop", 64'({cursor_x, cursor_y, valid}), 64'({10'd320, 10'd240, 1'b0}));

    step(1'b1, 1'b1, 1'b0, 9'd30, 9'd0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    chk("reset_flush", 64'({cursor_x, cursor_y, valid}), 64'({10'd320, 10'd240, 1'b0}));
    step(1'b1, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      step(1'(($urandom % 4) != 0), 1'($urandom), 1'($urandom),
           9'($urandom), 9'($urandom), 1'(($urandom % 40) == 0));
    end
    idle(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
